// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU control-step sequencer: state codes, execute modes, ALU selects.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_seq_pkg;

  // Control-step encoding; kept as plain constants so older tools that read state dumps see fixed codes.
  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_T0   = 4'd1;
  localparam state_t ST_T1   = 4'd2;
  localparam state_t ST_T1W  = 4'd3;
  localparam state_t ST_T2   = 4'd4;
  localparam state_t ST_T3   = 4'd5;
  localparam state_t ST_T4   = 4'd6;
  localparam state_t ST_T5   = 4'd7;
  localparam state_t ST_T6   = 4'd8;

  // Execute modes carried in the IR mode field.
  localparam logic [1:0] MODE_RR   = 2'd0;
  localparam logic [1:0] MODE_RI   = 2'd1;
  localparam logic [1:0] MODE_HILO = 2'd2;
  localparam logic [1:0] MODE_RSV  = 2'd3;

  // ALU select codes as decoded from the IR op field.
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_SHR = 5'b00111;
  localparam logic [4:0] ALU_SHL = 5'b01001;
  localparam logic [4:0] ALU_ROL = 5'b01110;
  localparam logic [4:0] ALU_ROR = 5'b01111;
  localparam logic [4:0] ALU_MUL = 5'b10000;
  localparam logic [4:0] ALU_DIV = 5'b10001;

endpackage

// File: rtl/onehot_dec.sv
// Register index to one-hot enable decoder with an in-range flag; out-of-range indices give all zeros.
// Latency: combinational.
// Backpressure: none.
module onehot_dec #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             vld
);

  // Full-width compare per bit, so an index >= N matches nothing instead of wrapping.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = (idx == IDX_W'(i));
    end
  end

  assign vld = |onehot;

endmodule

// File: rtl/alu_op_sequencer.sv
// Fetch (T0-T2) and register-ALU execute (T3-T6) control-step generator for the CPU datapath.
// Latency: start to IDLE is 7 cycles (reg-reg/reg-imm), 8 (HI/LO), 5 on abort, plus memory wait cycles.
// Backpressure: start only sampled while ready; T1W holds until mem_ready.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int SEL_W    = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  output logic                ready,
  output logic                done,
  output logic                err,
  input  logic                mem_ready,
  input  logic [SEL_W-1:0]    ir_op,
  input  logic [1:0]          ir_mode,
  input  logic [IDX_W-1:0]    ir_ra,
  input  logic [IDX_W-1:0]    ir_rb,
  input  logic [IDX_W-1:0]    ir_rc,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                lo_in,
  output logic                hi_in,
  output logic                c_out,
  output logic [SEL_W-1:0]    alu_sel
);

  state_t state_q, state_d;

  logic [SEL_W-1:0] op_q;
  logic [1:0]       mode_q;
  logic [IDX_W-1:0] ra_q, rc_q;

  logic                in_t3;
  logic [IDX_W-1:0]    ra_idx, rc_idx;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
  logic                ra_vld, rb_vld, rc_vld;
  logic                bad_instr;

  assign in_t3 = (state_q == ST_T3);

  // IR only becomes valid entering T3, so T3 decodes the live fields and later steps use the latched copies.
  assign ra_idx = in_t3 ? ir_ra : ra_q;
  assign rc_idx = in_t3 ? ir_rc : rc_q;

  onehot_dec #(.N(NUM_REGS), .IDX_W(IDX_W)) u_dec_rb (
    .idx    (ir_rb),
    .onehot (rb_oh),
    .vld    (rb_vld)
  );

  onehot_dec #(.N(NUM_REGS), .IDX_W(IDX_W)) u_dec_rc (
    .idx    (rc_idx),
    .onehot (rc_oh),
    .vld    (rc_vld)
  );

  onehot_dec #(.N(NUM_REGS), .IDX_W(IDX_W)) u_dec_ra (
    .idx    (ra_idx),
    .onehot (ra_oh),
    .vld    (ra_vld)
  );

  // Only meaningful in T3, where all decoders look at the live IR fields.
  assign bad_instr = (ir_mode == MODE_RSV) | ~ra_vld | ~rb_vld | ~rc_vld;

  // Control-step register; clr drops straight back to IDLE even mid-instruction.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the execute fields on the edge leaving T3.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q   <= '0;
      mode_q <= '0;
      ra_q   <= '0;
      rc_q   <= '0;
    end else if (in_t3) begin
      op_q   <= ir_op;
      mode_q <= ir_mode;
      ra_q   <= ir_ra;
      rc_q   <= ir_rc;
    end
  end

  // Step sequencing; start is ignored everywhere but IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T1W;
      ST_T1W:  if (mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = bad_instr ? ST_IDLE : ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (mode_q == MODE_HILO) ? ST_T6 : ST_IDLE;
      ST_T6:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode from registered state and latched fields only.
  always_comb begin
    ready   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    reg_in  = '0;
    reg_out = '0;
    pc_out  = 1'b0;
    mar_in  = 1'b0;
    inc_pc  = 1'b0;
    pc_in   = 1'b0;
    read    = 1'b0;
    mdr_in  = 1'b0;
    mdr_out = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    c_out   = 1'b0;
    alu_sel = '0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        zlo_out = 1'b1;
        pc_in   = 1'b1;
      end
      ST_T1W: begin
        read   = 1'b1;
        mdr_in = 1'b1;
      end
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        y_in    = 1'b1;
        reg_out = rb_oh;
        done    = bad_instr;
        err     = bad_instr;
      end
      ST_T4: begin
        z_in    = 1'b1;
        alu_sel = op_q;
        if (mode_q == MODE_RI) begin
          c_out = 1'b1;
        end else begin
          reg_out = rc_oh;
        end
      end
      ST_T5: begin
        zlo_out = 1'b1;
        if (mode_q == MODE_HILO) begin
          lo_in = 1'b1;
        end else begin
          reg_in = ra_oh;
          done   = 1'b1;
        end
      end
      ST_T6: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with an 8-register file and 4-bit indices.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int NR = 8;
  localparam int IW = 4;
  localparam int SW = 5;

  localparam logic [14:0] B_PC_OUT  = 15'h4000;
  localparam logic [14:0] B_MAR_IN  = 15'h2000;
  localparam logic [14:0] B_INC_PC  = 15'h1000;
  localparam logic [14:0] B_PC_IN   = 15'h0800;
  localparam logic [14:0] B_READ    = 15'h0400;
  localparam logic [14:0] B_MDR_IN  = 15'h0200;
  localparam logic [14:0] B_MDR_OUT = 15'h0100;
  localparam logic [14:0] B_IR_IN   = 15'h0080;
  localparam logic [14:0] B_Y_IN    = 15'h0040;
  localparam logic [14:0] B_Z_IN    = 15'h0020;
  localparam logic [14:0] B_ZLO     = 15'h0010;
  localparam logic [14:0] B_ZHI     = 15'h0008;
  localparam logic [14:0] B_LO_IN   = 15'h0004;
  localparam logic [14:0] B_HI_IN   = 15'h0002;
  localparam logic [14:0] B_C_OUT   = 15'h0001;

  typedef struct packed {
    logic [NR-1:0] reg_in;
    logic [NR-1:0] reg_out;
    logic [SW-1:0] alu_sel;
    logic [14:0]   strb;
    logic          done;
    logic          err;
  } obs_t;

  logic clk = 1'b0;
  logic clr, start, mem_ready;
  logic [SW-1:0] ir_op;
  logic [1:0]    ir_mode;
  logic [IW-1:0] ir_ra, ir_rb, ir_rc;
  logic ready, done, err;
  logic [NR-1:0] reg_in, reg_out;
  logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, c_out;
  logic [SW-1:0] alu_sel;

  obs_t exp_q[$];
  obs_t mon_a, mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .SEL_W(SW)) dut (
    .clk(clk), .clr(clr), .start(start), .ready(ready), .done(done), .err(err),
    .mem_ready(mem_ready), .ir_op(ir_op), .ir_mode(ir_mode),
    .ir_ra(ir_ra), .ir_rb(ir_rb), .ir_rc(ir_rc),
    .reg_in(reg_in), .reg_out(reg_out),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .lo_in(lo_in), .hi_in(hi_in), .c_out(c_out), .alu_sel(alu_sel)
  );

  function automatic obs_t sample();
    obs_t s;
    s.reg_in  = reg_in;
    s.reg_out = reg_out;
    s.alu_sel = alu_sel;
    s.strb    = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                 y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, c_out};
    s.done    = done;
    s.err     = err;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [14:0] strb, input logic [NR-1:0] rin, input logic [NR-1:0] rout,
                      input logic [SW-1:0] sel, input logic dn, input logic er);
    obs_t e;
    e.reg_in  = rin;
    e.reg_out = rout;
    e.alu_sel = sel;
    e.strb    = strb;
    e.done    = dn;
    e.err     = er;
    exp_q.push_back(e);
  endtask

  // Expected per-cycle strobes of one instruction, one queue entry per busy cycle.
  task automatic push_seq(input logic [1:0] mode, input logic [SW-1:0] op, input logic [NR-1:0] ra_oh,
                          input logic [NR-1:0] rb_oh, input logic [NR-1:0] rc_oh, input int waits,
                          input bit abort);
    push(B_PC_OUT | B_MAR_IN | B_INC_PC | B_Z_IN, '0, '0, '0, 1'b0, 1'b0);
    push(B_ZLO | B_PC_IN, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i <= waits; i++) push(B_READ | B_MDR_IN, '0, '0, '0, 1'b0, 1'b0);
    push(B_MDR_OUT | B_IR_IN, '0, '0, '0, 1'b0, 1'b0);
    push(B_Y_IN, '0, rb_oh, '0, abort, abort);
    if (!abort) begin
      if (mode == MODE_RI) push(B_Z_IN | B_C_OUT, '0, '0, op, 1'b0, 1'b0);
      else                 push(B_Z_IN, '0, rc_oh, op, 1'b0, 1'b0);
      if (mode == MODE_HILO) begin
        push(B_ZLO | B_LO_IN, '0, '0, '0, 1'b0, 1'b0);
        push(B_ZHI | B_HI_IN, '0, '0, '0, 1'b1, 1'b0);
      end else begin
        push(B_ZLO, ra_oh, '0, '0, 1'b1, 1'b0);
      end
    end
  endtask

  // Monitor: every busy cycle must match the next expected step; idle cycles must be quiet.
  always @(negedge clk) begin
    if (mon_en && clr) begin
      mon_a = sample();
      if (mon_a.done) done_seen++;
      checks++;
      if (!ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL busy_step: got reg_in=%h reg_out=%h sel=%h strb=%h done=%b err=%b, required no busy cycle",
                   mon_a.reg_in, mon_a.reg_out, mon_a.alu_sel, mon_a.strb, mon_a.done, mon_a.err);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL busy_step: got reg_in=%h reg_out=%h sel=%h strb=%h done=%b err=%b, required reg_in=%h reg_out=%h sel=%h strb=%h done=%b err=%b",
                     mon_a.reg_in, mon_a.reg_out, mon_a.alu_sel, mon_a.strb, mon_a.done, mon_a.err,
                     mon_e.reg_in, mon_e.reg_out, mon_e.alu_sel, mon_e.strb, mon_e.done, mon_e.err);
          end
        end
      end else if (mon_a !== '0) begin
        errors++;
        $display("FAIL idle_quiet: got %h required 0", mon_a);
      end
    end
  end

  task automatic run_instr(input string name, input logic [1:0] mode, input logic [SW-1:0] op,
                           input logic [IW-1:0] ra, input logic [IW-1:0] rb, input logic [IW-1:0] rc,
                           input logic [NR-1:0] ra_oh, input logic [NR-1:0] rb_oh, input logic [NR-1:0] rc_oh,
                           input int waits, input bit abort, input int exp_lat, input bit busy_pulse);
    int lat;
    int d0;
    @(negedge clk);
    ir_mode = mode; ir_op = op; ir_ra = ra; ir_rb = rb; ir_rc = rc;
    push_seq(mode, op, ra_oh, rb_oh, rc_oh, waits, abort);
    d0 = done_seen;
    start = 1'b1;
    mem_ready = (waits == 0);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 2 + waits) mem_ready = 1'b1;
      if (busy_pulse) start = (lat == 3);
      if (ready) break;
    end
    start = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " queue drained"}, 64'(exp_q.size()), 64'd0);
    check({name, " done pulses"}, 64'(done_seen - d0), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    clr = 1'b1; start = 1'b0; mem_ready = 1'b1;
    ir_op = '0; ir_mode = '0; ir_ra = '0; ir_rb = '0; ir_rc = '0;
    #2 clr = 1'b0;
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset outputs", 64'(sample()), 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    mon_en = 1'b1;

    //         name          mode       op       ra    rb    rc    ra_oh  rb_oh  rc_oh  wt ab lat bp
    run_instr("rr_ror",    MODE_RR,   ALU_ROR, 4'd6, 4'd6, 4'd4, 8'h40, 8'h40, 8'h10, 0, 0, 7,  0);
    run_instr("mem_wait",  MODE_RR,   ALU_ADD, 4'd1, 4'd2, 4'd3, 8'h02, 8'h04, 8'h08, 3, 0, 10, 0);
    run_instr("reg_imm",   MODE_RI,   ALU_ADD, 4'd2, 4'd1, 4'd0, 8'h04, 8'h02, 8'h01, 0, 0, 7,  0);
    run_instr("hilo_mul",  MODE_HILO, ALU_MUL, 4'd0, 4'd3, 4'd5, 8'h01, 8'h08, 8'h20, 0, 0, 8,  0);
    run_instr("bad_rc9",   MODE_RR,   ALU_ADD, 4'd1, 4'd2, 4'd9, 8'h02, 8'h04, 8'h00, 0, 1, 5,  0);
    run_instr("mode_rsv",  MODE_RSV,  ALU_ADD, 4'd1, 4'd2, 4'd3, 8'h02, 8'h04, 8'h08, 0, 1, 5,  0);
    run_instr("bad_rb8",   MODE_RR,   ALU_SUB, 4'd1, 4'd8, 4'd3, 8'h02, 8'h00, 8'h08, 0, 1, 5,  0);
    run_instr("bad_ra15",  MODE_RI,   ALU_SUB, 4'd15,4'd0, 4'd3, 8'h00, 8'h01, 8'h08, 0, 1, 5,  0);
    run_instr("top_reg7",  MODE_RR,   ALU_SUB, 4'd7, 4'd0, 4'd7, 8'h80, 8'h01, 8'h80, 0, 0, 7,  0);
    run_instr("busy_start",MODE_RR,   ALU_AND, 4'd3, 4'd4, 4'd5, 8'h08, 8'h10, 8'h20, 0, 0, 7,  1);

    // start held high: second instruction begins right after one idle cycle.
    @(negedge clk);
    ir_mode = MODE_RR; ir_op = ALU_OR; ir_ra = 4'd5; ir_rb = 4'd2; ir_rc = 4'd1;
    push_seq(MODE_RR, ALU_OR, 8'h20, 8'h04, 8'h02, 0, 1'b0);
    push_seq(MODE_RR, ALU_OR, 8'h20, 8'h04, 8'h02, 0, 1'b0);
    d0 = done_seen;
    mem_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (ready) break;
    end
    check("held first latency", 64'(lat), 64'd7);
    @(posedge clk);
    #1 start = 1'b0;
    check("held restart busy", 64'(ready), 64'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (ready) break;
    end
    check("held second latency", 64'(lat), 64'd7);
    check("held done pulses", 64'(done_seen - d0), 64'd2);
    check("held queue drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // clr asserted in T4 must clear every output within the cycle.
    @(negedge clk);
    mon_en = 1'b0;
    ir_mode = MODE_RR; ir_op = ALU_ROR; ir_ra = 4'd6; ir_rb = 4'd6; ir_rc = 4'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset in T4 sel", 64'(alu_sel), 64'(ALU_ROR));
    #2 clr = 1'b0;
    #1;
    check("mid_reset outputs", 64'(sample()), 64'd0);
    check("mid_reset ready", 64'(ready), 64'd1);
    @(negedge clk);
    clr = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    run_instr("after_reset", MODE_RI, ALU_SHL, 4'd3, 4'd0, 4'd0, 8'h08, 8'h01, 8'h01, 0, 0, 7, 0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
